// File: rtl/bj_predictor_if.sv
// bj_predictor_if: fetch lookup and EX training signals shared by the predictor and its pipeline.
interface bj_predictor_if #(parameter int PC_WD = 32);
  logic             fs_req;
  logic             fs_stall;
  logic [PC_WD-1:0] fs_pc;
  logic             pre_valid;
  logic             br_taken_pre;
  logic             btb_hit;
  logic [PC_WD-1:0] jt_pre;
  logic             es_upd;
  logic             es_branch;
  logic             es_jalr;
  logic [PC_WD-1:0] es_pc;
  logic             b_taken_real;
  logic [PC_WD-1:0] bj_addr;
  logic             pre_error;
  logic [31:0]      pre_cnt;
  logic [31:0]      err_cnt;
  modport master (
    output fs_req, fs_stall, fs_pc, es_upd, es_branch, es_jalr, es_pc, b_taken_real, bj_addr, pre_error,
    input  pre_valid, br_taken_pre, btb_hit, jt_pre, pre_cnt, err_cnt
  );
  modport slave (
    input  fs_req, fs_stall, fs_pc, es_upd, es_branch, es_jalr, es_pc, b_taken_real, bj_addr, pre_error,
    output pre_valid, br_taken_pre, btb_hit, jt_pre, pre_cnt, err_cnt
  );
endinterface

// File: rtl/bj_predictor.sv
// bj_predictor: 2-bit saturating BHT plus direct-mapped BTB, one-cycle registered lookup, trained from EX.
module bj_predictor #(
  parameter int PC_WD   = 32,
  parameter int BHT_IDX = 6,
  parameter int BTB_IDX = 4,
  parameter int TAG_WD  = 8
) (
  input logic        clk,
  input logic        reset,
  bj_predictor_if.slave bus
);
  localparam int NB = 1 << BHT_IDX;
  localparam int NT = 1 << BTB_IDX;
  logic [1:0]        bht_q [NB];
  logic              btb_v_q [NT];
  logic [TAG_WD-1:0] btb_tag_q [NT];
  logic [PC_WD-1:0]  btb_tgt_q [NT];
  logic              pre_valid_q, pre_valid_d, taken_q, taken_d, hit_q, hit_d, look_hit;
  logic [PC_WD-1:0]  jt_q, jt_d;
  logic [31:0]       pre_cnt_q, pre_cnt_d, err_cnt_q, err_cnt_d;
  logic              accept, upd_any, bht_wr, btb_wr;
  logic [BHT_IDX-1:0] l_bi, u_bi;
  logic [BTB_IDX-1:0] l_ti, u_ti;
  logic [TAG_WD-1:0]  l_tag, u_tag;
  logic [1:0]        ctr, ctr_d;
  always_comb begin
    l_bi        = bus.fs_pc[BHT_IDX+1:2];
    l_ti        = bus.fs_pc[BTB_IDX+1:2];
    l_tag       = bus.fs_pc[BTB_IDX+TAG_WD+1:BTB_IDX+2];
    u_bi        = bus.es_pc[BHT_IDX+1:2];
    u_ti        = bus.es_pc[BTB_IDX+1:2];
    u_tag       = bus.es_pc[BTB_IDX+TAG_WD+1:BTB_IDX+2];
    accept      = bus.fs_req & ~bus.fs_stall;
    look_hit    = btb_v_q[l_ti] & (btb_tag_q[l_ti] == l_tag);
    pre_valid_d = bus.fs_stall ? pre_valid_q : bus.fs_req;
    taken_d     = accept ? bht_q[l_bi][1] : taken_q;
    hit_d       = accept ? look_hit : hit_q;
    jt_d        = !accept ? jt_q : look_hit ? btb_tgt_q[l_ti] : bus.fs_pc + PC_WD'(4);
    upd_any     = bus.es_upd & (bus.es_branch | bus.es_jalr);
    bht_wr      = bus.es_upd & bus.es_branch;
    // a branch owns the BTB write decision even when jalr is also flagged
    btb_wr      = bus.es_upd & (bus.es_branch ? bus.b_taken_real : bus.es_jalr);
    ctr         = bht_q[u_bi];
    ctr_d       = bus.b_taken_real ? (ctr == 2'b11 ? ctr : ctr + 2'd1)
                                   : (ctr == 2'b00 ? ctr : ctr - 2'd1);
    pre_cnt_d   = pre_cnt_q + 32'(upd_any);
    err_cnt_d   = err_cnt_q + 32'(upd_any & bus.pre_error);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) bht_q[i] <= 2'b01;
      for (int i = 0; i < NT; i++) btb_v_q[i] <= 1'b0;
      pre_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      hit_q       <= 1'b0;
      jt_q        <= '0;
      pre_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      pre_valid_q <= pre_valid_d;
      taken_q     <= taken_d;
      hit_q       <= hit_d;
      jt_q        <= jt_d;
      pre_cnt_q   <= pre_cnt_d;
      err_cnt_q   <= err_cnt_d;
      if (bht_wr) bht_q[u_bi] <= ctr_d;
      if (btb_wr) btb_v_q[u_ti] <= 1'b1;
    end
  end
  // tag/target storage needs no reset: the valid bits gate every use
  always_ff @(posedge clk) begin
    if (!reset && btb_wr) begin
      btb_tag_q[u_ti] <= u_tag;
      btb_tgt_q[u_ti] <= bus.bj_addr;
    end
  end
  assign bus.pre_valid    = pre_valid_q;
  assign bus.br_taken_pre = taken_q;
  assign bus.btb_hit      = hit_q;
  assign bus.jt_pre       = jt_q;
  assign bus.pre_cnt      = pre_cnt_q;
  assign bus.err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_bj_predictor.sv
// tb_bj_predictor: directed vector table, hand sequences and random traffic against a behavioural model.
module tb_bj_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  bj_predictor_if #(.PC_WD(32)) bus();
  bj_predictor dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int          m_bht [64];
  bit          m_v [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  bit          m_pv, m_tk, m_hit;
  logic [31:0] m_jt, m_pre, m_err;
  typedef struct {
    bit req, stall; logic [31:0] pc;
    bit upd, br, jalr; logic [31:0] epc; bit tk; logic [31:0] addr;
    bit chk, pv, etk, ehit; logic [31:0] ejt;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(bit req, bit stall, logic [31:0] pc, bit upd, bit br, bit jalr,
                       logic [31:0] epc, bit tk, logic [31:0] addr, bit err);
    bus.fs_req = req; bus.fs_stall = stall; bus.fs_pc = pc;
    bus.es_upd = upd; bus.es_branch = br; bus.es_jalr = jalr; bus.es_pc = epc;
    bus.b_taken_real = tk; bus.bj_addr = addr; bus.pre_error = err;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
    m_pv = 0; m_tk = 0; m_hit = 0; m_jt = 0; m_pre = 0; m_err = 0;
  endtask
  task automatic model_step();
    int bi, ti;
    int unsigned tg;
    if (!bus.fs_stall) begin
      if (bus.fs_req) begin
        bi = int'((bus.fs_pc >> 2) % 64); ti = int'((bus.fs_pc >> 2) % 16); tg = (bus.fs_pc >> 6) % 256;
        m_pv = 1;
        m_tk = m_bht[bi] >= 2;
        m_hit = m_v[ti] && m_tag[ti] == tg;
        m_jt = m_hit ? m_tgt[ti] : bus.fs_pc + 32'd4;
      end else m_pv = 0;
    end
    if (bus.es_upd && (bus.es_branch || bus.es_jalr)) begin
      m_pre++;
      if (bus.pre_error) m_err++;
      bi = int'((bus.es_pc >> 2) % 64); ti = int'((bus.es_pc >> 2) % 16); tg = (bus.es_pc >> 6) % 256;
      if (bus.es_branch)
        m_bht[bi] = bus.b_taken_real ? (m_bht[bi] < 3 ? m_bht[bi] + 1 : 3) : (m_bht[bi] > 0 ? m_bht[bi] - 1 : 0);
      if (!bus.es_branch || bus.b_taken_real) begin
        m_v[ti] = 1; m_tag[ti] = tg; m_tgt[ti] = bus.bj_addr;
      end
    end
  endtask
  task automatic check_model();
    chk("pre_valid", bus.pre_valid, m_pv);
    chk("br_taken_pre", bus.br_taken_pre, m_tk);
    chk("btb_hit", bus.btb_hit, m_hit);
    chk("jt_pre", bus.jt_pre, m_jt);
    chk("pre_cnt", bus.pre_cnt, m_pre);
    chk("err_cnt", bus.err_cnt, m_err);
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask
  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    reset = 1'b0;
  endtask
  function automatic vec_t mv(bit req, bit stall, logic [31:0] pc, bit upd, bit br, bit jalr,
                              logic [31:0] epc, bit tk, logic [31:0] addr,
                              bit c, bit pv, bit etk, bit ehit, logic [31:0] ejt);
    vec_t v;
    v.req = req; v.stall = stall; v.pc = pc; v.upd = upd; v.br = br; v.jalr = jalr;
    v.epc = epc; v.tk = tk; v.addr = addr; v.chk = c; v.pv = pv; v.etk = etk; v.ehit = ehit; v.ejt = ejt;
    return v;
  endfunction
  function automatic vec_t lk(logic [31:0] pc, bit etk, bit ehit, logic [31:0] ejt);
    return mv(1, 0, pc, 0, 0, 0, 0, 0, 0, 1, 1, etk, ehit, ejt);
  endfunction
  function automatic vec_t ub(logic [31:0] epc, bit tk, logic [31:0] addr);
    return mv(0, 0, 0, 1, 1, 0, epc, tk, addr, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t uj(logic [31:0] epc, logic [31:0] addr);
    return mv(0, 0, 0, 1, 0, 1, epc, 0, addr, 0, 0, 0, 0, 0);
  endfunction
  initial begin
    logic [31:0] pc, epc;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    tbl.push_back(lk(32'h80000000, 0, 0, 32'h80000004));
    tbl.push_back(ub(32'h80000010, 1, 32'h80000100));
    tbl.push_back(ub(32'h80000010, 1, 32'h80000100));
    tbl.push_back(lk(32'h80000010, 1, 1, 32'h80000100));
    for (int i = 0; i < 3; i++) tbl.push_back(ub(32'h80000010, 0, 32'h80000014));
    tbl.push_back(lk(32'h80000010, 0, 1, 32'h80000100));
    tbl.push_back(ub(32'h80000010, 0, 32'h80000014));
    tbl.push_back(ub(32'h80000010, 1, 32'h80000100));
    tbl.push_back(lk(32'h80000010, 0, 1, 32'h80000100));
    tbl.push_back(uj(32'h80000020, 32'h80001234));
    tbl.push_back(lk(32'h80000020, 0, 1, 32'h80001234));
    tbl.push_back(uj(32'h80000420, 32'h80000999));
    tbl.push_back(lk(32'h80000020, 0, 0, 32'h80000024));
    tbl.push_back(lk(32'hFFFFFFFC, 0, 0, 32'h00000000));
    tbl.push_back(mv(1, 0, 32'h80000010, 1, 1, 0, 32'h80000010, 1, 32'h80000100, 1, 1, 0, 1, 32'h80000100));
    tbl.push_back(lk(32'h80000010, 1, 1, 32'h80000100));
    tbl.push_back(mv(1, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h80000100));
    tbl.push_back(mv(1, 1, 32'h80000020, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h80000100));
    tbl.push_back(mv(0, 1, 32'h80000044, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h80000100));
    tbl.push_back(lk(32'h80000000, 0, 0, 32'h80000004));
    tbl.push_back(mv(0, 0, 32'h80000010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h80000004));
    reset_dut();
    foreach (tbl[k]) begin
      drive(tbl[k].req, tbl[k].stall, tbl[k].pc, tbl[k].upd, tbl[k].br, tbl[k].jalr,
            tbl[k].epc, tbl[k].tk, tbl[k].addr, 0);
      tick();
      if (tbl[k].chk) begin
        chk($sformatf("vec%0d_pre_valid", k), bus.pre_valid, tbl[k].pv);
        chk($sformatf("vec%0d_taken", k), bus.br_taken_pre, tbl[k].etk);
        chk($sformatf("vec%0d_hit", k), bus.btb_hit, tbl[k].ehit);
        chk($sformatf("vec%0d_jt", k), bus.jt_pre, tbl[k].ejt);
      end
    end
    reset_dut();
    drive(0, 0, 0, 1, 1, 0, 32'h80000010, 1, 32'h80000100, 0); tick();
    drive(0, 0, 0, 1, 0, 1, 32'h80000020, 0, 32'h80001234, 1); tick();
    drive(0, 0, 0, 1, 0, 0, 32'h80000030, 1, 32'h80000777, 1); tick();
    drive(0, 0, 0, 1, 1, 0, 32'h80000014, 0, 32'h80000018, 0); tick();
    drive(0, 0, 0, 1, 1, 1, 32'h80000018, 1, 32'h80000200, 0); tick();
    drive(0, 0, 0, 1, 0, 1, 32'h80000024, 0, 32'h80000300, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("hand_pre_cnt", bus.pre_cnt, 32'd5);
    chk("hand_err_cnt", bus.err_cnt, 32'd2);
    drive(0, 0, 0, 1, 1, 0, 32'h80000040, 1, 32'h80000500, 1);
    reset_dut();
    chk("rst_pre_cnt", bus.pre_cnt, 32'd0);
    chk("rst_err_cnt", bus.err_cnt, 32'd0);
    drive(1, 0, 32'h80000040, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("rst_discard_hit", bus.btb_hit, 1'b0);
    chk("rst_discard_jt", bus.jt_pre, 32'h80000044);
    drive(1, 0, 32'h80000010, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("rst_btb_miss_10", bus.btb_hit, 1'b0);
    drive(1, 0, 32'h80000020, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("rst_btb_miss_20", bus.btb_hit, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'h80000000 + ($urandom_range(0, 127) << 2);
      epc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : 32'h80000000 + ($urandom_range(0, 127) << 2);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, pc, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, epc, $urandom_range(0, 1) == 1,
            $urandom(), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) reset_dut();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bj_predictor.md
Name: bj_predictor

Overview:
- Fetch-stage branch/jump predictor: 2-bit saturating-counter BHT for direction plus direct-mapped BTB for targets.
- Indexed by the fetch PC.
- Supplies the predicted-taken and predicted-target values that travel down the pipe to the EX-stage branch/jump target calculator.
- Trained from EX with the resolved outcome, resolved target and misprediction flag.

Parameters:
- PC_WD, 32, PC/address width
- BHT_IDX, 6, log2 of BHT entries (64)
- BTB_IDX, 4, log2 of BTB entries (16)
- TAG_WD, 8, BTB tag width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- fs_req  input  1  lookup request for fs_pc this cycle
- fs_stall  input  1  hold current prediction outputs
- fs_pc  input  PC_WD  fetch PC to look up
- pre_valid  output  1  prediction outputs correspond to last accepted fs_pc
- br_taken_pre  output  1  predicted branch direction (BHT counter MSB)
- btb_hit  output  1  BTB tag match with valid entry
- jt_pre  output  PC_WD  predicted target; BTB target on hit, else looked-up PC+4
- es_upd  input  1  EX resolved a branch or jalr this cycle
- es_branch  input  1  resolved instruction is a conditional branch
- es_jalr  input  1  resolved instruction is jalr
- es_pc  input  PC_WD  PC of resolved instruction
- b_taken_real  input  1  actual branch direction
- bj_addr  input  PC_WD  computed branch/jump target
- pre_error  input  1  EX detected misprediction
- pre_cnt  output  32  resolved branch/jalr count
- err_cnt  output  32  misprediction count

Behaviour:
- Reset (async, immediate):
  - All BHT counters = 2'b01 (weakly not-taken); all BTB valid bits = 0.
  - pre_valid = 0, br_taken_pre = 0, btb_hit = 0, jt_pre = 0, pre_cnt = 0, err_cnt = 0.
  - Reset mid-operation discards any in-flight lookup and update.
- Indexing:
  - BHT index = pc[BHT_IDX+1:2].
  - BTB index = pc[BTB_IDX+1:2].
  - BTB tag = pc[BTB_IDX+TAG_WD+1:BTB_IDX+2].
- Lookup latency is 1 cycle (registered, sync-SRAM style):
  - Cycle N: fs_req=1 and fs_stall=0 → fs_pc accepted.
  - Cycle N+1: outputs reflect that PC.
  - fs_stall=1 freezes all prediction outputs and ignores fs_req.
  - fs_req=0 with fs_stall=0 drives pre_valid to 0 next cycle; other prediction outputs hold their last values.
- jt_pre:
  - btb_hit → stored target.
  - Miss → accepted PC + 4, mod 2^PC_WD (wraps at 0xFFFFFFFC → 0x00000000).
- Updates are applied at the clk edge when es_upd=1:
  - es_branch:
    - BHT[idx(es_pc)] increments toward 2'b11 if b_taken_real, else decrements toward 2'b00; saturates at both ends.
    - If b_taken_real, BTB entry written: valid=1, tag(es_pc), target=bj_addr.
  - es_jalr: BTB entry written unconditionally with bj_addr; BHT untouched.
  - es_branch and es_jalr both 1: treated as branch.
  - Neither set: no table change.
- Counters:
  - pre_cnt increments on every es_upd with es_branch or es_jalr set.
  - err_cnt additionally increments if pre_error.
  - Both wrap at 2^32.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update value (read-before-write, no bypass). The updated value is visible to any lookup accepted in a later cycle.
- BTB replacement: direct-mapped, overwrite on write, no LRU.
- Tag mismatch with valid=1 is a miss.

Test Plan:
- Reset, then lookup fs_pc=0x80000000 → next cycle pre_valid=1, br_taken_pre=0, btb_hit=0, jt_pre=0x80000004.
- Update branch es_pc=0x80000010 taken, bj_addr=0x80000100, twice → lookup 0x80000010 gives br_taken_pre=1, btb_hit=1, jt_pre=0x80000100. Three not-taken updates → counter 2'b00, br_taken_pre=0. A fourth not-taken leaves the counter at 2'b00.
- jalr update es_pc=0x80000020, bj_addr=0x80001234 → lookup hits with jt_pre=0x80001234. Then jalr at 0x80000420 (same index, different tag) overwrites; lookup 0x80000020 misses with jt_pre=0x80000024.
- Same-cycle lookup and update of 0x80000010 starting from counter 2'b01, taken → returned br_taken_pre=0. Lookup in the following cycle returns 1.
- fs_stall=1 for 3 cycles while fs_pc changes → outputs unchanged. Deassert stall → new PC accepted, result next cycle.
- 5 updates with pre_error on 2 → pre_cnt=5, err_cnt=2. Assert reset mid-sequence → counters 0 and BTB miss on all previously trained PCs.
